// File: rtl/zrb_uart_rx_fifo_wr_if.sv
// Handshake bundle between the UART receiver and its FIFO-side environment.
// The receiver takes the slave view; the environment (baud tick, line, FIFO) takes the master view.
interface zrb_uart_rx_fifo_wr_if;
  logic       os_en;
  logic       rx;
  logic       fifo_full;
  logic       clr_err;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output os_en, rx, fifo_full, clr_err,
    input  wr_en, wr_data, busy, frame_err, overrun, parity_err
  );

  modport slave (
    input  os_en, rx, fifo_full, clr_err,
    output wr_en, wr_data, busy, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/zrb_uart_rx_fifo_wr.sv
// 8x-oversampling UART receiver writing good characters into the write side of an async FIFO.
// Optional even-parity bit is compiled in with the macro ZRB_UART_RX_PARITY_EN.
module zrb_uart_rx_fifo_wr #(
  parameter int NUM_BITS  = 8,
  parameter int STOP_BITS = 1
) (
  input logic                  wr_clk,
  input logic                  reset,
  zrb_uart_rx_fifo_wr_if.slave rx_if
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef ZRB_UART_RX_PARITY_EN
    PARITY = 3'd5,
`endif
    BRK    = 3'd4
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic       rx_meta_q, rxs_q;
  state_e     state_q, state_d;
  logic [2:0] tick_q, tick_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       stopcnt_q, stopcnt_d;
  logic       s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;
  logic [7:0] data_q, data_d;
  logic       wr_en_q, wr_fire;
  logic [7:0] wr_data_q;
  logic       frame_err_q, overrun_q, fe_set, ov_set;
  logic       busy;
  logic       maj_late, maj_early, last_bit, last_stop;
`ifdef ZRB_UART_RX_PARITY_EN
  logic       par_q, par_d, parity_ok, parity_err_q, pe_set;
`endif

  // Line synchronizer: idles high so reset never looks like a start bit.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // maj_late votes on stored ticks 3/4/5 (used at tick 7); maj_early uses the live tick-5 sample.
  assign maj_late  = maj3(s3_q, s4_q, s5_q);
  assign maj_early = maj3(s3_q, s4_q, rxs_q);
  assign last_bit  = (bitcnt_q == 3'(NUM_BITS - 1));
  assign last_stop = (stopcnt_q == 1'(STOP_BITS - 1));
`ifdef ZRB_UART_RX_PARITY_EN
  assign parity_ok = ~((^data_q) ^ par_q);
`endif

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= 3'd0;
      bitcnt_q    <= 3'd0;
      stopcnt_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ZRB_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bitcnt_q    <= bitcnt_d;
      stopcnt_q   <= stopcnt_d;
      wr_en_q     <= wr_fire;
      if (wr_fire) wr_data_q <= data_q;
      frame_err_q <= fe_set | (frame_err_q & ~rx_if.clr_err);
      overrun_q   <= ov_set | (overrun_q & ~rx_if.clr_err);
`ifdef ZRB_UART_RX_PARITY_EN
      parity_err_q <= pe_set | (parity_err_q & ~rx_if.clr_err);
`endif
    end
  end

  always_ff @(posedge wr_clk) begin
    s3_q   <= s3_d;
    s4_q   <= s4_d;
    s5_q   <= s5_d;
    data_q <= data_d;
`ifdef ZRB_UART_RX_PARITY_EN
    par_q  <= par_d;
`endif
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    s3_d      = s3_q;
    s4_d      = s4_q;
    s5_d      = s5_q;
    data_d    = data_q;
`ifdef ZRB_UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    if (rx_if.os_en) begin
      if (tick_q == 3'd3) s3_d = rxs_q;
      if (tick_q == 3'd4) s4_d = rxs_q;
      if (tick_q == 3'd5) s5_d = rxs_q;
      tick_d = tick_q + 3'd1;
      unique case (state_q)
        IDLE: begin
          tick_d = 3'd0;
          if (!rxs_q) begin
            state_d = START;
            tick_d  = 3'd1;
          end
        end
        START: begin
          if (tick_q == 3'd7) begin
            if (maj_late) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bitcnt_d  = 3'd0;
              stopcnt_d = 1'b0;
              data_d    = 8'd0;
            end
          end
        end
        DATA: begin
          if (tick_q == 3'd7) begin
            data_d[bitcnt_q] = maj_late;
            bitcnt_d         = bitcnt_q + 3'd1;
            if (last_bit) begin
`ifdef ZRB_UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef ZRB_UART_RX_PARITY_EN
        PARITY: begin
          if (tick_q == 3'd7) begin
            par_d   = maj_late;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          // The final stop bit decides at tick 5 so a following start edge is not missed.
          if (last_stop && tick_q == 3'd5) begin
            state_d = maj_early ? IDLE : BRK;
            tick_d  = 3'd0;
          end else if (!last_stop && tick_q == 3'd7) begin
            if (maj_late) stopcnt_d = stopcnt_q + 1'b1;
            else          state_d   = BRK;
          end
        end
        BRK: begin
          tick_d = 3'd0;
          if (rxs_q) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          tick_d  = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    wr_fire = 1'b0;
    fe_set  = 1'b0;
    ov_set  = 1'b0;
`ifdef ZRB_UART_RX_PARITY_EN
    pe_set  = 1'b0;
`endif
    if (rx_if.os_en && state_q == STOP) begin
      if (last_stop && tick_q == 3'd5) begin
        if (!maj_early)            fe_set  = 1'b1;
`ifdef ZRB_UART_RX_PARITY_EN
        else if (!parity_ok)       pe_set  = 1'b1;
`endif
        else if (rx_if.fifo_full)  ov_set  = 1'b1;
        else                       wr_fire = 1'b1;
      end else if (!last_stop && tick_q == 3'd7 && !maj_late) begin
        fe_set = 1'b1;
      end
    end
  end

  assign rx_if.wr_en     = wr_en_q;
  assign rx_if.wr_data   = wr_data_q;
  assign rx_if.busy      = busy;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
`ifdef ZRB_UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule
